bcd_text_formatter: RTL

//   Sequential binary-to-BCD converter and ASCII line formatter.

---
 rtl/bcd_text_formatter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/bcd_text_formatter.sv
// Double-dabble binary-to-BCD converter (one bit per clock) with a registered "COUNT:dddd" ASCII line; done 15 cycles after the start cycle, start ignored unless idle.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits in the text line only.
module bcd_text_formatter #(
  parameter int               WIDTH   = 14,
  parameter logic [WIDTH-1:0] MAX_VAL = 14'd9999
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow,
  output logic [3:0]       o_units,
  output logic [3:0]       o_tens,
  output logic [3:0]       o_hundreds,
  output logic [3:0]       o_thousands,
  output logic [127:0]     o_line
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FORMAT} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_bin;
  logic [15:0]      r_bcd;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf_pend;
  logic             r_busy;
  logic             r_done;
  logic             r_overflow;
  logic [15:0]      r_digits;
  logic [127:0]     r_line;

  logic [14:0]      w_bcd_adj;
  logic [15:0]      w_bcd_next;
  logic [7:0]       w_c6, w_c7, w_c8, w_c9;
  logic [127:0]     w_line;

  function automatic logic [7:0] f_ascii(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  // Top nibble never exceeds 4 before a shift for in-range values, so its carry-out bit is dropped.
  always_comb begin
    w_bcd_adj = r_bcd[14:0];
    for (int i = 0; i < 3; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5)
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    if (r_bcd[15:12] >= 4'd5)
      w_bcd_adj[14:12] = r_bcd[14:12] + 3'd3;
  end

  assign w_bcd_next = {w_bcd_adj, r_bin[WIDTH-1]};

  always_comb begin
    w_c6 = f_ascii(w_bcd_next[15:12]);
    w_c7 = f_ascii(w_bcd_next[11:8]);
    w_c8 = f_ascii(w_bcd_next[7:4]);
    w_c9 = f_ascii(w_bcd_next[3:0]);
`ifdef LEADING_ZERO_BLANK_EN
    if (w_bcd_next[15:12] == 4'd0) begin
      w_c6 = 8'h20;
      if (w_bcd_next[11:8] == 4'd0) begin
        w_c7 = 8'h20;
        if (w_bcd_next[7:4] == 4'd0)
          w_c8 = 8'h20;
      end
    end
`endif
  end

  assign w_line = {8'h43, 8'h4F, 8'h55, 8'h4E, 8'h54, 8'h3A,
                   w_c6, w_c7, w_c8, w_c9, {6{8'h20}}};

  // Results are captured on the final shift edge so they appear together with done in FORMAT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_digits   <= '0;
      r_line     <= {16{8'h20}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            if (i_value > MAX_VAL) begin
              r_bin      <= MAX_VAL;
              r_ovf_pend <= 1'b1;
            end else begin
              r_bin      <= i_value;
              r_ovf_pend <= 1'b0;
            end
            r_bcd   <= '0;
            r_cnt   <= CW'(WIDTH);
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd <= w_bcd_next;
          r_bin <= {r_bin[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_digits   <= w_bcd_next;
            r_line     <= w_line;
            r_overflow <= r_ovf_pend;
            r_done     <= 1'b1;
            r_state    <= S_FORMAT;
          end
        end
        S_FORMAT: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_overflow  = r_overflow;
  assign o_thousands = r_digits[15:12];
  assign o_hundreds  = r_digits[11:8];
  assign o_tens      = r_digits[7:4];
  assign o_units     = r_digits[3:0];
  assign o_line      = r_line;

endmodule
